// File: rtl/alu_op_issue_if.sv
// Issue-stage bus between the fetch/register-read side and the ALU side.
// The master drives instructions in and consumes issued operands. The slave is
// the issue stage itself.
interface alu_op_issue_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_branch;
  logic             br_invert;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_ctrl, op_a, op_b, is_branch, br_invert,
           illegal, illegal_count
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_ctrl, op_a, op_b, is_branch, br_invert,
           illegal, illegal_count
  );
endinterface

// File: rtl/alu_op_issue.sv
// RV32I decode/issue stage: turns an instruction and its register operands
// into an ALU control code plus A/B operands, held in a one-entry pipeline
// register. It also keeps a saturating count of illegal instructions.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so the register accepts a new
// entry when it is empty or when its current entry drains on the same edge.
// While out_valid && !out_ready, every output holds bit-stable.
module alu_op_issue #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  alu_op_issue_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Shared funct3 mapping for OP and OP-IMM. The alternate funct7 forms
  // (SUB/SRA) are resolved by the caller.
  function automatic alu_ctrl_e f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm, s_imm, u_imm, shamt;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign i_imm  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign s_imm  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign u_imm  = {bus.instr[31:12], 12'b0};
  assign shamt  = {27'b0, bus.instr[24:20]};

  alu_ctrl_e        d_ctrl;
  logic [WIDTH-1:0] d_a, d_b;
  logic             d_br, d_inv, d_ill;

  // Decode the incoming instruction. Illegal encodings collapse to an
  // all-zero payload with only the illegal flag set.
  always_comb begin
    d_ctrl = ALU_ADD;
    d_a    = '0;
    d_b    = '0;
    d_br   = 1'b0;
    d_inv  = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_a    = bus.rs1_data;
        d_b    = bus.rs2_data;
        d_ctrl = f3_ctrl(funct3);
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      d_ctrl = ALU_SUB;
          else if (funct3 == 3'b101) d_ctrl = ALU_SRA;
          else                       d_ill  = 1'b1;
        end else if (funct7 != F7_ZERO) begin
          d_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d_a    = bus.rs1_data;
        d_b    = i_imm;
        d_ctrl = f3_ctrl(funct3);
        if (funct3 == 3'b001) begin
          d_b = shamt;
          if (funct7 != F7_ZERO) d_ill = 1'b1;
        end else if (funct3 == 3'b101) begin
          d_b = shamt;
          if (funct7 == F7_ALT)       d_ctrl = ALU_SRA;
          else if (funct7 != F7_ZERO) d_ill  = 1'b1;
        end
      end
      OPC_LUI: begin
        d_b = u_imm;
      end
      OPC_AUIPC: begin
        d_a = bus.pc;
        d_b = u_imm;
      end
      OPC_LOAD: begin
        d_a = bus.rs1_data;
        d_b = i_imm;
      end
      OPC_STORE: begin
        d_a = bus.rs1_data;
        d_b = s_imm;
      end
      OPC_BRANCH: begin
        d_a  = bus.rs1_data;
        d_b  = bus.rs2_data;
        d_br = 1'b1;
        case (funct3)
          3'b000:  begin d_ctrl = ALU_SUB;  d_inv = 1'b0; end
          3'b001:  begin d_ctrl = ALU_SUB;  d_inv = 1'b1; end
          3'b100:  begin d_ctrl = ALU_SLT;  d_inv = 1'b1; end
          3'b101:  begin d_ctrl = ALU_SLT;  d_inv = 1'b0; end
          3'b110:  begin d_ctrl = ALU_SLTU; d_inv = 1'b1; end
          3'b111:  begin d_ctrl = ALU_SLTU; d_inv = 1'b0; end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctrl = ALU_ADD;
      d_a    = '0;
      d_b    = '0;
      d_br   = 1'b0;
      d_inv  = 1'b0;
    end
  end

  logic             out_valid_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             br_q, inv_q, ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready;
  logic             accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Pipeline register and illegal counter. Reset beats flush, and flush
  // beats accept. A flushed accept leaves payload and counter untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      inv_q       <= 1'b0;
      ill_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= d_ctrl;
      a_q         <= d_a;
      b_q         <= d_b;
      br_q        <= d_br;
      inv_q       <= d_inv;
      ill_q       <= d_ill;
      if (d_ill && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.alu_ctrl      = ctrl_q;
  assign bus.op_a          = a_q;
  assign bus.op_b          = b_q;
  assign bus.is_branch     = br_q;
  assign bus.br_invert     = inv_q;
  assign bus.illegal       = ill_q;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed instruction vectors whose expected ALU
// payloads are pushed into a queue at accept time. A separate monitor pops and
// compares every entry that the ALU side takes.
module tb_alu_op_issue;

  localparam int EW = 87;  // {ctrl4, a32, b32, br, inv, ill, cnt16}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_op_issue_if #(.WIDTH(32), .CNT_W(16)) bus ();

  alu_op_issue #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_cnt = '0;

  function automatic logic [EW-1:0] pack(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic br,
                                         input logic inv, input logic ill,
                                         input logic [15:0] cnt);
    pack = {c, a, b, br, inv, ill, cnt};
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    dut_vec = pack(bus.alu_ctrl, bus.op_a, bus.op_b, bus.is_branch,
                   bus.br_invert, bus.illegal, bus.illegal_count);
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: at the falling edge, a visible valid&&ready means the entry is
  // taken on the coming rising edge (inputs only move just after rising edges).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 &&
        bus.flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h", dut_vec());
      end else begin
        check("scoreboard", dut_vec(), exp_q.pop_front());
      end
    end
  end

  // Driver: present one instruction and hold it until accepted.
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [3:0] c, input logic [31:0] ea,
                       input logic [31:0] eb, input logic br, input logic inv,
                       input logic ill);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.pc       = p;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        if (ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back(pack(c, ea, eb, br, inv, ill, exp_cnt));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout instr=%h", i);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%b want 0/0", exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_payload", dut_vec(), pack(4'h0, 0, 0, 0, 0, 0, 16'h0));
    check("reset_out_valid", EW'(bus.out_valid), EW'(0));
    check("reset_in_ready", EW'(bus.in_ready), EW'(1));
    tick();
    rst_n = 1'b1;

    // Decode vectors: instr, pc, rs1, rs2 -> ctrl, a, b, br, inv, ill
    issue(32'h40B50533, 32'h100, 32'd7, 32'd9, 4'b0001, 32'd7, 32'd9, 0, 0, 0);  // SUB
    issue(32'h40335293, 32'h104, 32'h8000_0000, 32'd0, 4'b0111, 32'h8000_0000, 32'd3, 0, 0, 0);  // SRAI 3
    issue(32'hFFF00093, 32'h108, 32'h55, 32'd0, 4'b0000, 32'h55, 32'hFFFF_FFFF, 0, 0, 0);  // ADDI -1
    issue(32'h123450B7, 32'h10C, 32'hDEAD, 32'd1, 4'b0000, 32'd0, 32'h1234_5000, 0, 0, 0);  // LUI
    issue(32'h00001097, 32'h2000, 32'hAA, 32'd1, 4'b0000, 32'h2000, 32'h0000_1000, 0, 0, 0);  // AUIPC
    issue(32'hFE20AE23, 32'h114, 32'h400, 32'h77, 4'b0000, 32'h400, 32'hFFFF_FFFC, 0, 0, 0);  // SW -4
    issue(32'h00209463, 32'h118, 32'd5, 32'd5, 4'b0001, 32'd5, 32'd5, 1, 1, 0);  // BNE
    issue(32'h0020F463, 32'h11C, 32'd5, 32'd5, 4'b1001, 32'd5, 32'd5, 1, 0, 0);  // BGEU
    issue(32'h0020C463, 32'h120, 32'd3, 32'd4, 4'b0101, 32'd3, 32'd4, 1, 1, 0);  // BLT
    issue(32'h00000000, 32'h124, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // all-zero word, count 1
    issue(32'h023100B3, 32'h128, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // funct7 0000001, count 2
    issue(32'h0020A463, 32'h12C, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // branch funct3 010
    issue(32'h40109093, 32'h130, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // SLLI with funct7 0100000
    issue(32'h40317033, 32'h134, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // AND with funct7 0100000
    issue(32'h00000010, 32'h138, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 0, 0, 1);  // instr[1:0] != 11
    wait_drain();

    // Backpressure: hold entry A for 3 cycles with B waiting, then stream B..D
    bus.out_ready = 1'b0;
    r1 = 32'($urandom_range(0, 32'hFFFF));
    r2 = 32'($urandom_range(0, 32'hFFFF));
    issue(32'h00208033, 32'h200, r1, r2, 4'b0000, r1, r2, 0, 0, 0);  // ADD
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0020C033;
    bus.rs1_data = 32'h1111;
    bus.rs2_data = 32'h2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_in_ready", EW'(bus.in_ready), EW'(0));
      check("hold_payload", dut_vec(), exp_q[0]);
      tick();
    end
    bus.out_ready = 1'b1;
    issue(32'h0020C033, 32'h204, 32'h1111, 32'h2222, 4'b0100, 32'h1111, 32'h2222, 0, 0, 0);  // XOR
    issue(32'h0020B033, 32'h208, 32'h3333, 32'h4444, 4'b1001, 32'h3333, 32'h4444, 0, 0, 0);  // SLTU
    issue(32'h0020D033, 32'h20C, 32'hF000_0000, 32'd4, 4'b0110, 32'hF000_0000, 32'd4, 0, 0, 0);  // SRL
    wait_drain();

    // Flush coincident with an accept of an illegal word: dropped, count unchanged
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    check("flush_accept_valid", EW'(bus.out_valid), EW'(0));
    check("flush_accept_count", EW'(bus.illegal_count), EW'(exp_cnt));
    tick();

    // Flush of a held entry
    bus.out_ready = 1'b0;
    issue(32'h00208033, 32'h300, 32'd1, 32'd1, 4'b0000, 32'd1, 32'd1, 0, 0, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_held_valid", EW'(bus.out_valid), EW'(0));
    tick();

    // Reset while holding an entry
    issue(32'h00209463, 32'h400, 32'd8, 32'd9, 4'b0001, 32'd8, 32'd9, 1, 1, 0);
    @(negedge clk);
    check("pre_reset_valid", EW'(bus.out_valid), EW'(1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    exp_cnt = '0;
    @(negedge clk);
    check("mid_reset_payload", dut_vec(), pack(4'h0, 0, 0, 0, 0, 0, 16'h0));
    check("mid_reset_valid", EW'(bus.out_valid), EW'(0));
    check("mid_reset_in_ready", EW'(bus.in_ready), EW'(1));
    tick();
    bus.out_ready = 1'b1;

    // Saturation: 65535 illegal entries reach all-ones, one more stays there
    for (int n = 0; n < 65536; n++) begin
      r1 = $urandom_range(0, 1000);
      issue(32'h0, r1, r1, r1, 4'b0000, 32'd0, 32'd0, 0, 0, 1);
    end
    wait_drain();
    check("saturated_count", EW'(bus.illegal_count), EW'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
